dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder_ram.sv | 29 ++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state encoding and bus geometry.
package dmem_responder_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int DATA_MEM_DEPTH = 1024;
   localparam int DMEM_BE_WIDTH  = DATA_WIDTH / 8;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef enum logic [1:0] {DMEM_IDLE, DMEM_READ, DMEM_RESP} dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between the MEM-stage initiator and the data-memory responder.
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_responder_ram.sv
// Single-port word-organised synchronous RAM with byte enables.
// Read-first: a write cycle returns the old word; one cycle read latency.
module dmem_ram
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH = DATA_MEM_DEPTH,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [DMEM_BE_WIDTH-1:0] we,
   input  logic [AW-1:0]            addr,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int i = 0; i < DMEM_BE_WIDTH; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one load/store at a time, performs it on the
// data RAM with byte/half/word sizing, and returns data or an error flag.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH = DATA_MEM_DEPTH,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = DATA_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   dmem_responder_if.slave    bus
);

   localparam logic [1:0] S_IDLE = 2'(DMEM_IDLE);
   localparam logic [1:0] S_READ = 2'(DMEM_READ);
   localparam logic [1:0] S_RESP = 2'(DMEM_RESP);

   function automatic logic req_is_err(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
      logic unsupported;
      logic misaligned;
      if (we) unsupported = (f3 > FUNCT3_SW);
      else    unsupported = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      case (f3[1:0])
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = (off != 2'b00);
         default: misaligned = 1'b0;
      endcase
      return unsupported || misaligned;
   endfunction

   function automatic logic [DMEM_BE_WIDTH-1:0] store_be(input logic [2:0] f3,
                                                         input logic [1:0] off);
      case (f3)
         FUNCT3_SB: return 4'b0001 << off;
         FUNCT3_SH: return off[1] ? 4'b1100 : 4'b0011;
         FUNCT3_SW: return 4'b1111;
         default:   return 4'b0000;
      endcase
   endfunction

   function automatic logic [DW-1:0] store_data(input logic [2:0] f3,
                                                input logic [DW-1:0] w);
      case (f3)
         FUNCT3_SB: return {4{w[7:0]}};
         FUNCT3_SH: return {2{w[15:0]}};
         default:   return w;
      endcase
   endfunction

   // Byte/half selection from the addressed lane, then sign or zero extension.
   function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = signed'(word[8*off +: 8]);
      h = signed'(word[16*off[1] +: 16]);
      case (f3)
         FUNCT3_LB:  return DW'(b);
         FUNCT3_LBU: return DW'(unsigned'(b));
         FUNCT3_LH:  return DW'(h);
         FUNCT3_LHU: return DW'(unsigned'(h));
         FUNCT3_LW:  return word;
         default:    return '0;
      endcase
   endfunction

   logic [1:0]               state;
   logic                     accept;
   logic                     acc_err;
   logic                     ram_en;
   logic [DMEM_BE_WIDTH-1:0] ram_we;
   logic [DW-1:0]            ram_rdata;
   logic [2:0]               funct3_p0;
   logic [1:0]               off_p0;
   logic [DW-1:0]            rsp_rdata_q;
   logic                     rsp_err_q;
   logic                     unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[31:AW+2];

   assign accept  = bus.req_valid && (state == S_IDLE);
   assign acc_err = req_is_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
   assign ram_en  = accept && !acc_err;
   assign ram_we  = (ram_en && bus.req_we) ? store_be(bus.req_funct3, bus.req_addr[1:0]) : '0;

   dmem_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (bus.req_addr[AW+1:2]),
      .wdata (store_data(bus.req_funct3, bus.req_wdata)),
      .rdata (ram_rdata)
   );

   // Accept stage: remember how to extract the load while the RAM read is in flight.
   always_ff @(posedge clk) begin
      if (accept) begin
         funct3_p0 <= bus.req_funct3;
         off_p0    <= bus.req_addr[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= acc_err;
                  state       <= (acc_err || bus.req_we) ? S_RESP : S_READ;
               end
            end
            // Read stage: RAM word is valid now; register the extended result.
            S_READ: begin
               rsp_rdata_q <= load_extend(ram_rdata, funct3_p0, off_p0);
               rsp_err_q   <= 1'b0;
               state       <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state == S_IDLE);
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a word-array memory model.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [31:0] mem_m [1024];

   dmem_responder_if bus ();

   dmem_responder u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
      if (we && f3 > 2) return 1;
      if (!we && (f3 == 3 || f3 >= 6)) return 1;
      if ((f3 % 4) == 1 && (a % 2) != 0) return 1;
      if ((f3 % 4) == 2 && (a % 4) != 0) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w, v;
      int off;
      w = mem_m[(a / 4) % 1024];
      off = int'(a % 4);
      v = 0;
      if (f3 == 0 || f3 == 4) begin
         v = (w >> (8 * off)) & 32'hFF;
         if (f3 == 0 && v >= 128) v = v | 32'hFFFFFF00;
      end else if (f3 == 1 || f3 == 5) begin
         v = (w >> (16 * (off / 2))) & 32'hFFFF;
         if (f3 == 1 && v >= 32768) v = v | 32'hFFFF0000;
      end else if (f3 == 2) begin
         v = w;
      end
      return v;
   endfunction

   task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int idx, off;
      logic [31:0] mask;
      idx = int'((a / 4) % 1024);
      off = int'(a % 4);
      if (f3 == 0) begin
         mask = 32'hFF << (8 * off);
         mem_m[idx] = (mem_m[idx] & ~mask) | ((wd & 32'hFF) << (8 * off));
      end else if (f3 == 1) begin
         mask = 32'hFFFF << (16 * (off / 2));
         mem_m[idx] = (mem_m[idx] & ~mask) | ((wd & 32'hFFFF) << (16 * (off / 2)));
      end else begin
         mem_m[idx] = wd;
      end
   endtask

   task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold, output logic [31:0] rd);
      bit          e;
      logic [31:0] exp_d;
      int          exp_lat, lat;
      e = m_err(we, f3, addr);
      exp_d = (e || we) ? 32'h0 : m_load(f3, addr);
      exp_lat = (e || we) ? 1 : 2;
      rd = 32'hX;
      @(negedge clk);
      check_val("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.req_funct3 = f3;
      bus.req_addr = addr;
      bus.req_wdata = wd;
      bus.rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_we = 1'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_addr = $urandom;
      bus.req_wdata = $urandom;
      lat = 1;
      while (!bus.rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check_val("latency", 32'(lat), 32'(exp_lat));
      if (!bus.rsp_valid) return;
      if (we && !e) m_store(f3, addr, wd);
      rd = bus.rsp_rdata;
      check_val("rsp_rdata", bus.rsp_rdata, exp_d);
      check_val("rsp_err", 32'(bus.rsp_err), 32'(e));
      check_val("req_ready_busy", 32'(bus.req_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("hold_valid", 32'(bus.rsp_valid), 32'd1);
         check_val("hold_rdata", bus.rsp_rdata, exp_d);
         check_val("hold_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check_val("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("idle_req_ready", 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_funct3 = 3'b0;
      bus.req_addr = 32'h0;
      bus.req_wdata = 32'h0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check_val("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      rst_n = 1'b1;

      xact(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd);
      check_val("sw_rdata_zero", rd, 32'h0);
      xact(0, 3'd2, 32'h10, 32'h0, 0, rd);
      check_val("lw_deadbeef", rd, 32'hDEADBEEF);

      xact(1, 3'd2, 32'h10, 32'h11223344, 0, rd);
      xact(1, 3'd0, 32'h13, 32'h00000080, 0, rd);
      xact(0, 3'd2, 32'h10, 32'h0, 0, rd);
      check_val("sb_word", rd, 32'h80223344);
      xact(0, 3'd0, 32'h13, 32'h0, 0, rd);
      check_val("lb_neg", rd, 32'hFFFFFF80);
      xact(0, 3'd4, 32'h13, 32'h0, 0, rd);
      check_val("lbu", rd, 32'h00000080);

      xact(1, 3'd2, 32'h20, 32'hCAFE1234, 0, rd);
      xact(1, 3'd1, 32'h22, 32'h00008001, 0, rd);
      xact(0, 3'd1, 32'h22, 32'h0, 0, rd);
      check_val("lh_neg", rd, 32'hFFFF8001);
      xact(0, 3'd5, 32'h22, 32'h0, 0, rd);
      check_val("lhu", rd, 32'h00008001);
      xact(0, 3'd1, 32'h20, 32'h0, 0, rd);
      check_val("lh_low", rd, 32'h00001234);

      xact(0, 3'd2, 32'h21, 32'h0, 0, rd);
      xact(1, 3'd1, 32'h23, 32'hFFFFFFFF, 0, rd);
      xact(0, 3'd6, 32'h20, 32'h0, 0, rd);
      xact(1, 3'd3, 32'h20, 32'hFFFFFFFF, 0, rd);
      xact(0, 3'd2, 32'h20, 32'h0, 0, rd);
      check_val("mem_after_err", rd, 32'h80011234);

      xact(0, 3'd2, 32'h10, 32'h0, 5, rd);

      xact(1, 3'd2, 32'h1000, 32'hA5A5A5A5, 0, rd);
      xact(0, 3'd2, 32'h0, 32'h0, 0, rd);
      check_val("wrap", rd, 32'hA5A5A5A5);

      // Reset while a load sits in READ.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we = 1'b0;
      bus.req_funct3 = 3'd2;
      bus.req_addr = 32'h10;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_val("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("arst_req_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      xact(0, 3'd2, 32'h10, 32'h0, 0, rd);
      check_val("after_rst", rd, 32'h80223344);

      for (int i = 0; i < 16; i++) xact(1, 3'd2, 32'h100 + 32'(4 * i), $urandom, 0, rd);
      for (int i = 0; i < 150; i++) begin
         a = ($urandom & 32'hFFFFF000) | (32'h100 + 32'($urandom_range(0, 63)));
         xact(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 2), rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
